// File: rtl/aes_pkg.sv
// Shared AES types and constants for the cipher pipeline.
// Byte k of a state or word sits at bits [8k:8k+7].
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int NB        = 4;

  typedef logic [3:0]   round_t;
  typedef logic [0:127] state_t;
  typedef logic [0:31]  word_t;

  function automatic int key_words(input int nr);
    return NB * (nr + 1);
  endfunction

endpackage

// File: rtl/aes_skid_fifo2.sv
// Two-entry valid/ready FIFO with a registered in_ready.
// en_i gates whether new entries may be accepted next cycle.
module aes_skid_fifo2 #(
  parameter int WIDTH = 134
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q;
  logic             rd_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic             push;
  logic             pop;

  assign push        = in_valid_i & rdy_q;
  assign pop         = out_valid_o & out_ready_i;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_q];
  assign in_ready_o  = rdy_q;

  // Occupancy after this cycle's push/pop, and readiness derived from it.
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      push & !pop: cnt_d = cnt_q + 2'd1;
      pop & !push: cnt_d = cnt_q - 2'd1;
      default:     cnt_d = cnt_q;
    endcase
    rdy_d = en_i & (cnt_d < 2'd2);
  end

  // Storage, pointers, count and ready register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
      rdy_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= in_data_i;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end

endmodule

// File: rtl/inv_add_round_key_stage.sv
// Decrypt-path AddRoundKey: key schedule RAM, round-key XOR,
// InvMixColumns bypass flag and a 2-entry output queue.
module inv_add_round_key_stage
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_wr_en,
  input  logic [5:0]   key_wr_addr,
  input  logic [0:31]  key_wr_data,
  input  logic         key_clear,
  output logic         key_loaded,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic [3:0]   in_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic [3:0]   out_round,
  output logic         out_mix_bypass,
  output logic         out_err
);

  localparam int         KEY_WORDS = key_words(NR);
  localparam logic [6:0] KW7       = 7'(KEY_WORDS);
  localparam round_t     NR4       = round_t'(NR);

  word_t               kmem [KEY_WORDS];
  logic [KEY_WORDS-1:0] bmp_q, bmp_d;
  logic                loaded_q, loaded_d;
  logic                wr_ok;
  logic                err;
  logic                byp;
  round_t              rsel;
  logic [5:0]          base;
  state_t              rkey;
  state_t              xst;
  logic [133:0]        fin;
  logic [133:0]        fout;

  assign wr_ok = key_wr_en & ({1'b0, key_wr_addr} < KW7);

  // Bitmap of written words; clear has priority over a write.
  always_comb begin
    bmp_d = bmp_q;
    if (key_clear)  bmp_d = '0;
    else if (wr_ok) bmp_d[key_wr_addr] = 1'b1;
    loaded_d = &bmp_d;
  end

  // Bitmap and loaded flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmp_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      bmp_q    <= bmp_d;
      loaded_q <= loaded_d;
    end
  end

  // Key RAM; contents only matter once every word has been written.
  always_ff @(posedge clk) begin
    if (wr_ok && !key_clear) kmem[key_wr_addr] <= key_wr_data;
  end

  assign key_loaded = loaded_q;

  // Round-key read (pre-write contents) and XOR; bad rounds pass through.
  always_comb begin
    err  = (in_round > NR4);
    byp  = err | (in_round == NR4) | (in_round == 4'd0);
    rsel = err ? 4'd0 : in_round;
    base = {rsel, 2'b00};
    rkey = {kmem[base], kmem[base + 6'd1],
            kmem[base + 6'd2], kmem[base + 6'd3]};
    xst  = err ? in_state : (in_state ^ rkey);
    fin  = {xst, in_round, byp, err};
  end

  aes_skid_fifo2 #(.WIDTH(134)) u_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (loaded_d),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (fin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (fout)
  );

  assign out_state      = fout[133:6];
  assign out_round      = fout[5:2];
  assign out_mix_bypass = fout[1];
  assign out_err        = fout[0];

endmodule

// File: tb/tb_inv_add_round_key_stage.sv
// Directed bench for inv_add_round_key_stage using the
// FIPS-197 AES-128 key schedule for key 000102..0f.
module tb_inv_add_round_key_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_wr_en;
  logic [5:0]   key_wr_addr;
  logic [0:31]  key_wr_data;
  logic         key_clear;
  logic         key_loaded;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic [3:0]   in_round;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;
  logic [3:0]   out_round;
  logic         out_mix_bypass;
  logic         out_err;

  always #5 clk = ~clk;

  inv_add_round_key_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_wr_en      (key_wr_en),
    .key_wr_addr    (key_wr_addr),
    .key_wr_data    (key_wr_data),
    .key_clear      (key_clear),
    .key_loaded     (key_loaded),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_state       (in_state),
    .in_round       (in_round),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_state      (out_state),
    .out_round      (out_round),
    .out_mix_bypass (out_mix_bypass),
    .out_err        (out_err)
  );

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] st;
    logic [127:0] exp;
    logic         byp;
    logic         err;
  } vec_t;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [127:0] rk [11];
  vec_t         tv [12];

  localparam logic [127:0] FIPS_IN10  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_OUT10 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] FIPS_IN9   = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] FIPS_OUT9  = 128'he9f74eec023020f61bf2ccf2353c21c7;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] kw(input int i);
    logic [127:0] r;
    r = rk[i / 4];
    return r[127 - 32 * (i % 4) -: 32];
  endfunction

  task automatic load_keys();
    for (int i = 0; i < 44; i++) begin
      key_wr_en   = 1'b1;
      key_wr_addr = 6'(i);
      key_wr_data = kw(i);
      if (i == 43) chk("loaded_before_last", key_loaded, 0);
      step();
    end
    key_wr_en = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic [127:0] st,
                         input logic [3:0] r, input logic b, input logic e);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_state"}, out_state, st);
    chk({nm, "_round"}, out_round, r);
    chk({nm, "_byp"}, out_mix_bypass, b);
    chk({nm, "_err"}, out_err, e);
  endtask

  initial begin
    int           bad;
    int           acc;
    logic [127:0] k2;
    logic [127:0] xs;

    rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    tv[0] = '{4'd9, FIPS_IN9, FIPS_OUT9, 1'b0, 1'b0};
    for (int k = 1; k < 9; k++) begin
      tv[k].rnd = 4'(9 - k);
      tv[k].st  = 128'h00112233445566778899aabbccddeeff ^ {16{8'(k * 17)}};
      tv[k].exp = tv[k].st ^ rk[9 - k];
      tv[k].byp = 1'b0;
      tv[k].err = 1'b0;
    end
    tv[9]  = '{4'd0, 128'hfedcba98765432100123456789abcdef,
               128'hfedcba98765432100123456789abcdef ^ rk[0], 1'b1, 1'b0};
    tv[10] = '{4'd11, 128'hdeadbeefcafef00d0123456789abcdef,
               128'hdeadbeefcafef00d0123456789abcdef, 1'b1, 1'b1};
    tv[11] = '{4'd15, 128'h55aa55aa33cc33cc0ff00ff012345678,
               128'h55aa55aa33cc33cc0ff00ff012345678, 1'b1, 1'b1};

    rst_n = 1'b0; key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0;
    key_clear = 1'b0; in_valid = 1'b0; in_state = '0; in_round = '0;
    out_ready = 1'b0;
    #22;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_key_loaded", key_loaded, 0);
    chk("rst_out_state", out_state, 0);
    chk("rst_flags", {out_round, out_mix_bypass, out_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // No keys: nothing is accepted for 20 cycles.
    in_valid = 1'b1; in_state = FIPS_IN10; in_round = 4'd10;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (in_ready || out_valid) bad++;
    end
    chk("nokey_idle", bad, 0);
    in_valid = 1'b0;

    load_keys();
    chk("loaded", key_loaded, 1);
    chk("ready_after_load", in_ready, 1);

    // Final decrypt round (first inverse round), single transaction.
    out_ready = 1'b1;
    in_valid = 1'b1; in_state = FIPS_IN10; in_round = 4'd10;
    step();
    in_valid = 1'b0;
    chk_out("r10", FIPS_OUT10, 4'd10, 1'b1, 1'b0);
    step();
    chk("r10_drained", out_valid, 0);

    // Back-to-back table: one result per cycle, in order.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_state = tv[i].st; in_round = tv[i].rnd;
      chk($sformatf("tv%0d_ready", i), in_ready, 1);
      step();
      chk_out($sformatf("tv%0d", i), tv[i].exp, tv[i].rnd,
              tv[i].byp, tv[i].err);
    end
    in_valid = 1'b0;
    step();
    chk("tv_drained", out_valid, 0);

    // Backpressure: 3 offered, 2 accepted.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_state = tv[i + 1].st; in_round = tv[i + 1].rnd;
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", in_ready, 0);
    step();
    chk_out("bp_hold", tv[1].exp, tv[1].rnd, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk_out("bp_second", tv[2].exp, tv[2].rnd, 1'b0, 1'b0);
    chk("bp_ready_back", in_ready, 1);
    step();
    chk("bp_drained", out_valid, 0);

    // Out-of-range key writes are ignored.
    key_wr_en = 1'b1; key_wr_addr = 6'd44; key_wr_data = 32'hffffffff;
    step();
    key_wr_addr = 6'd63;
    step();
    key_wr_en = 1'b0;
    chk("oor_loaded", key_loaded, 1);
    in_valid = 1'b1; in_state = FIPS_IN10; in_round = 4'd10;
    step();
    chk_out("oor_r10", FIPS_OUT10, 4'd10, 1'b1, 1'b0);

    // Same-cycle write to w[40] does not affect this accept.
    xs = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    in_state = xs;
    key_wr_en = 1'b1; key_wr_addr = 6'd40; key_wr_data = 32'hffffffff;
    step();
    key_wr_en = 1'b0;
    chk("rbw_old", out_state, xs ^ rk[10]);
    k2 = rk[10];
    k2[127:96] = 32'hffffffff;
    step();
    in_valid = 1'b0;
    chk("rbw_new", out_state, xs ^ k2);
    key_wr_en = 1'b1; key_wr_addr = 6'd40; key_wr_data = kw(40);
    step();
    key_wr_en = 1'b0;
    chk("rbw_drained", out_valid, 0);

    // key_clear with two queued entries.
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = FIPS_IN10; in_round = 4'd10;
    step();
    in_state = FIPS_IN9; in_round = 4'd9;
    step();
    key_clear = 1'b1;
    step();
    key_clear = 1'b0;
    chk("clr_loaded", key_loaded, 0);
    chk("clr_in_ready", in_ready, 0);
    out_ready = 1'b1;
    chk_out("clr_first", FIPS_OUT10, 4'd10, 1'b1, 1'b0);
    step();
    chk_out("clr_second", FIPS_OUT9, 4'd9, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid || in_ready) bad++;
    end
    chk("clr_no_accept", bad, 0);
    in_valid = 1'b0;

    // Async reset mid-stream.
    load_keys();
    out_ready = 1'b0;
    in_valid = 1'b1; in_state = FIPS_IN10; in_round = 4'd10;
    step();
    step();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_loaded", key_loaded, 0);
    chk("arst_state", out_state, 0);
    #10;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
